// File: rtl/rv_lsu.sv
// rv_lsu: single-outstanding load/store unit between a pipeline request
// port and a word-wide synchronous data memory with byte write enables.
//
// Parameters
//   ADDR_W   data-memory word-address width (DM_A width)
//   TIMEOUT  maximum ACCESS cycles waiting for DM_READY (LSU_TIMEOUT_EN only)
//
// Build option
//   LSU_TIMEOUT_EN  when defined, an ACCESS that sees no DM_READY within
//                   TIMEOUT cycles completes with resp_err=1; otherwise the
//                   unit waits for DM_READY indefinitely.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_op                      [3]=store, [2]=unsigned load, [1:0]=size
//   req_addr/req_wdata/req_rd   byte address, store data, load tag
//   resp_valid/resp_ready       response handshake
//   resp_rdata/resp_rd/resp_err extended load data, echoed tag, error flag
//   DM_CS/DM_OE/DM_WEB          memory select, output enable, byte writes (active-low)
//   DM_A/DM_DI/DM_DO/DM_READY   word address, write data, read data, access done
module rv_lsu #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              DM_CS,
  output logic              DM_OE,
  output logic [3:0]        DM_WEB,
  output logic [ADDR_W-1:0] DM_A,
  output logic [31:0]       DM_DI,
  input  logic [31:0]       DM_DO,
  input  logic              DM_READY
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [3:0]  web_st;
  logic [31:0] di_st;
  logic [31:0] lane_data;
  logic [31:0] load_data;
  logic        in_access;
  logic        timeout_hit;

  // Misaligned or reserved-size requests never reach the memory.
  always_comb begin
    unique case (req_op[1:0])
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Store lane enables and replicated write data from the latched request.
  always_comb begin
    web_st = 4'b1111;
    di_st  = wdata_q;
    case (op_q[1:0])
      2'd0: begin
        web_st = ~(4'b0001 << addr_q[1:0]);
        di_st  = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        web_st = addr_q[1] ? 4'b0011 : 4'b1100;
        di_st  = {2{wdata_q[15:0]}};
      end
      2'd2:    web_st = 4'b0000;
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by size.
  always_comb begin
    lane_data = DM_DO >> {addr_q[1:0], 3'b000};
    case (op_q[1:0])
      2'd0:    load_data = {{24{~op_q[2] & lane_data[7]}}, lane_data[7:0]};
      2'd1:    load_data = {{16{~op_q[2] & lane_data[15]}}, lane_data[15:0]};
      default: load_data = DM_DO;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt_q;
  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
            if (req_err) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              rdata_q      <= '0;
            end else begin
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          // DM_READY wins over a timeout expiring on the same edge.
          if (DM_READY || timeout_hit) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            err_q        <= ~DM_READY;
            rdata_q      <= (DM_READY && !op_q[3]) ? load_data : 32'd0;
          end
`ifdef LSU_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory outputs depend only on registered state, so they hold steady
  // for the whole ACCESS and drop to idle values immediately on reset.
  always_comb begin
    in_access = (state_q == StAccess);
    DM_CS     = in_access;
    DM_OE     = in_access & ~op_q[3];
    DM_WEB    = (in_access && op_q[3]) ? web_st : 4'b1111;
    DM_A      = in_access ? addr_q[ADDR_W+1:2] : '0;
    DM_DI     = in_access ? di_st : '0;
  end

  logic unused_addr;
  assign unused_addr = ^addr_q[31:ADDR_W+2];

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_rv_lsu.sv
`timescale 1ns/1ps
module tb_rv_lsu;
  localparam int unsigned AW = 14;
`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif
  localparam int NEVER = 1000;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic [4:0]    resp_rd;
  logic          resp_err;
  logic          DM_CS;
  logic          DM_OE;
  logic [3:0]    DM_WEB;
  logic [AW-1:0] DM_A;
  logic [31:0]   DM_DI;
  logic [31:0]   DM_DO;
  logic          DM_READY;

  rv_lsu #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .DM_CS(DM_CS), .DM_OE(DM_OE), .DM_WEB(DM_WEB), .DM_A(DM_A),
    .DM_DI(DM_DI), .DM_DO(DM_DO), .DM_READY(DM_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        err;
    int          first_cyc;
    logic        commit;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbytes;
  } resp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    web;
    logic [31:0]   di;
    logic          oe;
    int            delay;
  } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];
  logic [31:0] mem_ref [int];
  logic [31:0] mem_dut [int];
  logic [31:0] last_rdata;
  logic        last_err;
  logic [3:0]  last_web;
  logic [31:0] last_di;

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ref_word(input int k);
    if (mem_ref.exists(k)) return mem_ref[k];
    return init_word(k);
  endfunction

  function automatic logic [31:0] dut_word(input int k);
    if (mem_dut.exists(k)) return mem_dut[k];
    return init_word(k);
  endfunction

  // Memory responder: checks every ACCESS cycle against the expected access,
  // answers after the chosen delay and applies the DUT's own byte writes.
  initial begin
    int waited;
    acc_t e;
    logic [31:0] w;
    waited   = 0;
    DM_READY = 1'b0;
    DM_DO    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_q.delete();
        waited   = 0;
        DM_READY = 1'b0;
      end else if (DM_CS) begin
        if (acc_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_dm_cs: actual 1, required 0 (cycle %0d)", cyc);
          DM_READY = 1'b0;
        end else begin
          e = acc_q[0];
          check("dm_a", 32'(DM_A), 32'(e.a));
          check("dm_web", 32'(DM_WEB), 32'(e.web));
          check("dm_di", DM_DI, e.di);
          check("dm_oe", 32'(DM_OE), 32'(e.oe));
          if (e.delay == waited) begin
            DM_READY = 1'b1;
            DM_DO    = dut_word(int'(DM_A));
            w        = DM_DO;
            for (int i = 0; i < 4; i++) if (!DM_WEB[i]) w[8*i +: 8] = DM_DI[8*i +: 8];
            mem_dut[int'(DM_A)] = w;
            last_web = DM_WEB;
            last_di  = DM_DI;
            void'(acc_q.pop_front());
            waited = 0;
          end else if (e.delay == NEVER && waited == int'(TMO) - 1) begin
            DM_READY = 1'b0;
            DM_DO    = $urandom;
            void'(acc_q.pop_front());
            waited = 0;
          end else begin
            DM_READY = 1'b0;
            DM_DO    = $urandom;
            waited++;
          end
        end
      end else begin
        DM_READY = 1'($urandom_range(0, 1));
        DM_DO    = $urandom;
      end
    end
  end

  // Response monitor: compares every presented response cycle and retires
  // the scoreboard entry on the handshake, committing stores to the model.
  initial begin
    bit first_seen;
    resp_t r;
    logic [31:0] w;
    int k;
    first_seen = 0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_q.delete();
        first_seen = 0;
        resp_ready = 1'($urandom_range(0, 1));
      end else if (resp_valid) begin
        resp_ready = ($urandom_range(0, 9) < 6);
        if (resp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_resp: actual 1, required 0 (cycle %0d)", cyc);
        end else begin
          r = resp_q[0];
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_rd", 32'(resp_rd), 32'(r.rd));
          check("resp_err", 32'(resp_err), 32'(r.err));
          check("req_ready_busy", 32'(req_ready), 32'd0);
          if (!first_seen) begin
            check("resp_latency", 32'(cyc), 32'(r.first_cyc));
            first_seen = 1;
          end
          if (resp_ready) begin
            void'(resp_q.pop_front());
            first_seen = 0;
            last_rdata = resp_rdata;
            last_err   = resp_err;
            if (r.commit) begin
              k = int'(r.addr[AW+1:2]);
              w = ref_word(k);
              for (int i = 0; i < r.nbytes; i++)
                w[8*(int'(r.addr[1:0]) + i) +: 8] = r.wdata[8*i +: 8];
              mem_ref[k] = w;
            end
          end
        end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Issue one request, then push the expected access and response.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int delay);
    bit got;
    int n, lane, k;
    resp_t r;
    acc_t a;
    logic [31:0] w;
    logic [63:0] v;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
      // Garbage while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 4'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_rd    = 5'($urandom);
    end
    if (!got) begin
      n_err++;
      $display("FAIL req_ready_wait: actual 0, required 1 (cycle %0d)", cyc);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_addr  = $urandom;

    lane     = int'(addr[1:0]);
    k        = int'(addr[AW+1:2]);
    r.rd     = rd;
    r.addr   = addr;
    r.wdata  = wdata;
    r.commit = 1'b0;
    r.rdata  = '0;
    n        = (op[1:0] == 2'd3) ? 8 : (1 << op[1:0]);
    r.nbytes = n;
    if (op[1:0] == 2'd3 || (lane % n) != 0) begin
      r.err       = 1'b1;
      r.first_cyc = cyc;
    end else begin
      a.a     = addr[AW+1:2];
      a.oe    = ~op[3];
      a.delay = delay;
      a.web   = 4'b1111;
      if (op[3]) for (int i = 0; i < n; i++) a.web[lane + i] = 1'b0;
      for (int i = 0; i < 4; i++) a.di[8*i +: 8] = wdata[8*(i % n) +: 8];
      acc_q.push_back(a);
      if (delay == NEVER) begin
        r.err       = 1'b1;
        r.first_cyc = cyc + int'(TMO);
      end else begin
        r.err       = 1'b0;
        r.first_cyc = cyc + delay + 1;
        if (op[3]) begin
          r.commit = 1'b1;
        end else begin
          w = ref_word(k);
          v = '0;
          for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(lane + i) +: 8];
          if (!op[2] && v[8*n - 1]) v = v - (64'd1 << (8 * n));
          r.rdata = v[31:0];
        end
      end
    end
    resp_q.push_back(r);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (resp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_err++;
      $display("FAIL drain_timeout: actual %0d pending, required 0", resp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    int dly;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_rd    = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_dm_cs", 32'(DM_CS), 32'd0);
    check("rst_dm_web", 32'(DM_WEB), 32'hF);
    check("rst_dm_a", 32'(DM_A), 32'd0);
    check("rst_dm_di", DM_DI, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Directed cases.
    issue(4'b1010, 32'h100, 32'h80FF_1234, 5'd1, 0);
    issue(4'b0000, 32'h103, 32'h0, 5'd2, 0);
    wait_idle();
    check("lb_0x103", last_rdata, 32'hFFFF_FF80);
    issue(4'b1010, 32'h200, 32'h9ABC_0000, 5'd3, 1);
    issue(4'b0101, 32'h202, 32'h0, 5'd4, 0);
    wait_idle();
    check("lhu_0x202", last_rdata, 32'h0000_9ABC);
    check("lhu_err", 32'(last_err), 32'd0);
    issue(4'b1000, 32'h11, 32'h55, 5'd5, 0);
    wait_idle();
    check("sb_web", 32'(last_web), 32'hD);
    check("sb_di", last_di, 32'h5555_5555);
    issue(4'b1001, 32'h12, 32'h1234_ABCD, 5'd6, 2);
    wait_idle();
    check("sh_web", 32'(last_web), 32'h3);
    issue(4'b0010, 32'h6, 32'h0, 5'd7, 0);
    wait_idle();
    check("lw_misaligned_err", 32'(last_err), 32'd1);
    issue(4'b0011, 32'h0, 32'h0, 5'd8, 0);
    wait_idle();
    check("size3_err", 32'(last_err), 32'd1);
    issue(4'b1010, 32'h40, 32'hCAFE_F00D, 5'd9, 3);
    issue(4'b0010, 32'h40, 32'h0, 5'd10, 3);
    wait_idle();
    check("lw_after_stall", last_rdata, 32'hCAFE_F00D);
`ifdef LSU_TIMEOUT_EN
    issue(4'b0010, 32'h44, 32'h0, 5'd11, NEVER);
    wait_idle();
    check("timeout_err", 32'(last_err), 32'd1);
    check("timeout_rdata", last_rdata, 32'd0);
`endif

    // Reset during the ACCESS of a word store.
    issue(4'b1010, 32'h300, 32'hDEAD_BEEF, 5'd12, 3);
    @(negedge clk);
    check("rst_pre_cs", 32'(DM_CS), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_abort_web", 32'(DM_WEB), 32'hF);
    check("rst_abort_cs", 32'(DM_CS), 32'd0);
    check("rst_abort_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_req_ready", 32'(req_ready), 32'd1);
    check("rst_release_resp_valid", 32'(resp_valid), 32'd0);
    issue(4'b0010, 32'h300, 32'h0, 5'd13, 0);
    wait_idle();
    check("aborted_store_not_written", last_rdata, init_word(32'h300 >> 2));

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      op[3]   = 1'($urandom_range(0, 1));
      op[2]   = 1'($urandom_range(0, 1));
      op[1:0] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      dly     = $urandom_range(0, 3);
`ifdef LSU_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) dly = NEVER;
`endif
      issue(op, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63)),
            $urandom, 5'($urandom), dly);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 SHALL provide parameter ADDR_W, default 14, giving the data-memory word-address width.
REQ-002 SHALL provide parameter TIMEOUT, default 255, giving the maximum DM_READY wait in cycles (1..65535).
REQ-003 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_valid input 1 request present, and req_ready output 1 LSU can accept.
REQ-006 SHALL have port req_op  input  4  [3]=store, [2]=unsigned load, [1:0]=size (0 byte, 1 half, 2 word, 3 reserved).
REQ-007 SHALL have ports req_addr input 32 byte address, req_wdata input 32 store data (low bits used), and req_rd input 5 load destination tag.
REQ-008 SHALL have ports resp_valid output 1 result present, and resp_ready input 1 consumer accepts.
REQ-009 SHALL have ports resp_rdata output 32 extended load data (0 for stores/errors), resp_rd output 5 echoed tag, and resp_err output 1 misaligned/reserved/timeout.
REQ-010 SHALL have memory ports DM_CS out 1, DM_OE out 1, DM_WEB out 4 (active-low byte write), DM_A out ADDR_W, DM_DI out 32, DM_DO in 32, and DM_READY in 1 (access complete this cycle).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-012 SHALL, on req_valid&req_ready, latch op/addr/wdata/rd; valid aligned op -> ACCESS next cycle; otherwise -> RESP with resp_err=1 and no memory access.
REQ-013 SHALL flag error when size=3, when half and addr[0]=1, or when word and addr[1:0]!=0; unsigned bit ignored for stores.
REQ-014 SHALL, in ACCESS, drive DM_CS=1, DM_A=addr[ADDR_W+1:2], DM_OE=1 for loads only; DM_CS=0, DM_OE=0, DM_WEB=4'b1111 in all other states.
REQ-015 SHALL drive DM_WEB in ACCESS for stores: byte 4'b1110 rotated left by addr[1:0] (lane 3 -> 4'b0111); half 4'b1100 if addr[1]=0 else 4'b0011 (active-low lanes 1:0 / 3:2); word 4'b0000; loads 4'b1111.
REQ-016 SHALL drive DM_DI as byte replicated x4, half replicated x2, word unchanged.
REQ-017 SHALL hold all DM outputs stable in ACCESS until DM_READY=1 sampled; on that edge capture DM_DO (loads) and go RESP.
REQ-018 SHALL extract load data by lane (byte addr[1:0], half addr[1]) and sign-extend unless op[2]=1 (zero-extend).
REQ-019 SHALL assert resp_valid only in RESP, holding resp_rdata/resp_rd/resp_err stable until resp_valid&resp_ready, then return to IDLE.
REQ-020 SHALL give latency: accept at edge N, DM_READY high during first ACCESS cycle -> resp_valid in cycle N+2; error -> resp_valid in cycle N+1.
REQ-021 SHALL accept no new request in the cycle resp handshake completes (no bypass); next accept is earliest one cycle later.
REQ-022 SHALL ignore DM_READY and DM_DO outside ACCESS.

Reset
REQ-023 SHALL, on rst assertion, immediately enter IDLE and clear resp_valid, resp_rdata, resp_rd, resp_err, and all latched request fields to 0, forcing DM_CS=0, DM_OE=0, DM_WEB=4'b1111, DM_A=0, DM_DI=0.
REQ-024 SHALL abort any in-flight ACCESS or pending RESP on reset with no partial write continuing, and SHALL present req_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with LSU_TIMEOUT_EN defined, count ACCESS cycles and, if DM_READY has not been seen after TIMEOUT cycles, leave ACCESS for RESP with resp_err=1 and resp_rdata=0; counter clears on entering ACCESS.
REQ-026 SHALL, without LSU_TIMEOUT_EN, omit the counter and wait in ACCESS indefinitely for DM_READY.

Verification
REQ-027 SHALL cover: LB addr 0x103, DM_DO=0x80FF_1234, DM_READY in first ACCESS cycle -> DM_A=0x40, resp_rdata=0xFFFF_FF80, resp_valid cycle N+2.
REQ-028 SHALL cover: LHU addr 0x202, DM_DO=0x9ABC_0000 -> resp_rdata=0x0000_9ABC, resp_err=0.
REQ-029 SHALL cover: SB addr 0x11, wdata 0x55 -> DM_WEB=4'b1101, DM_DI=0x5555_5555; SH addr 0x12 -> DM_WEB=4'b0011.
REQ-030 SHALL cover: LW addr 0x6 -> no DM_CS pulse, resp_err=1 in cycle N+1; op size=3 -> same.
REQ-031 SHALL cover: DM_READY held low 3 cycles and resp_ready low 2 cycles -> DM outputs and response stable throughout; with LSU_TIMEOUT_EN and TIMEOUT=4, DM_READY never high -> resp_err=1 after 4 ACCESS cycles.
REQ-032 SHALL cover: rst pulsed during ACCESS of SW -> DM_WEB=4'b1111 immediately, resp_valid=0, req_ready=1 after release.
